r_responder: RTL

Single-clock AXI read-data responder: the R-channel transmitter at the slave end of the crossbar read path. It accepts one AR request at a time, generates the beat addresses (FIXED/INCR/WRAP), reads a 1-cycle-latency synchronous memory port, and drives RID/RDATA/RRESP/RLAST with VALID/READY handshaking. Its R outputs feed the crossbar's per-slave R FIFO push side.

---
 rtl/r_responder_pkg.sv | 27 ++
 rtl/axi_burst_addr_gen.sv | 46 ++++
 rtl/r_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/r_responder_pkg.sv
// Shared types and constants for the AXI read-data responder and its address generator.
// Optional WRAP support is selected by the R_RESPONDER_WRAP_EN macro.
package r_responder_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend,
    StErr
  } state_t;

  // WRAP bursts must be 2, 4, 8 or 16 beats long.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address calculator (FIXED/INCR, WRAP when R_RESPONDER_WRAP_EN).
// Shared between read and write responders.
module axi_burst_addr_gen
  import r_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_size,
  input  logic [3:0]            i_len,
  input  burst_t                i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  localparam logic [ADDR_WIDTH-1:0] One = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_aligned;

  assign w_bytes   = One << i_size;
  // Unaligned INCR starts snap to the beat size from the second beat on.
  assign w_aligned = i_addr & ~(w_bytes - One);

`ifdef R_RESPONDER_WRAP_EN
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_wrap_next;

  assign w_wrap_mask = ((ADDR_WIDTH'(i_len) + One) << i_size) - One;
  assign w_wrap_next = (i_addr & ~w_wrap_mask) | ((i_addr + w_bytes) & w_wrap_mask);
`else
  logic w_unused_len;
  assign w_unused_len = ^i_len;
`endif

  always_comb begin
    o_next_addr = i_addr;
    case (i_burst)
      BurstIncr: o_next_addr = w_aligned + w_bytes;
`ifdef R_RESPONDER_WRAP_EN
      BurstWrap: o_next_addr = w_wrap_next;
`endif
      default:   o_next_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/r_responder.sv
// AXI R-channel responder: one AR burst at a time, 1-cycle synchronous memory, SLVERR for
// illegal requests. WRAP bursts are accepted only when R_RESPONDER_WRAP_EN is defined.
module r_responder
  import r_responder_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned MaxSize = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] BeatMask = ADDR_WIDTH'(DATA_WIDTH / 8) - ADDR_WIDTH'(1);

  state_t                r_state, w_state_d;
  logic                  r_arready;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [3:0]            r_len;
  logic [3:0]            r_cnt;
  logic [2:0]            r_size;
  burst_t                r_burst;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_fresh;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_last;
  logic                  w_illegal;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .i_addr     (r_addr),
    .i_size     (r_size),
    .i_len      (r_len),
    .i_burst    (r_burst),
    .o_next_addr(w_next_addr)
  );

  assign w_ar_hs = ARVALID & r_arready;
  assign w_r_hs  = RVALID & RREADY;
  assign w_last  = (r_cnt == r_len);

  always_comb begin
    w_illegal = (32'(ARSIZE) > MaxSize) || (ARBURST == 2'b11);
`ifdef R_RESPONDER_WRAP_EN
    if ((ARBURST == 2'b10) && !wrap_len_ok(ARLEN)) w_illegal = 1'b1;
`else
    if (ARBURST == 2'b10) w_illegal = 1'b1;
`endif
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_ar_hs) w_state_d = w_illegal ? StErr : StFetch;
      StFetch: w_state_d = StSend;
      StSend:  if (w_r_hs) w_state_d = w_last ? StIdle : StFetch;
      StErr:   if (w_r_hs && w_last) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_arready <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= BurstFixed;
      r_rdata   <= '0;
      r_fresh   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_arready <= (w_state_d == StIdle);
      // First SEND cycle passes mem_rdata through and captures it for any stall.
      r_fresh   <= (r_state == StFetch);
      if (r_fresh) r_rdata <= mem_rdata;
      if (w_ar_hs) begin
        r_id    <= ARID;
        r_addr  <= ARADDR;
        r_len   <= ARLEN;
        r_size  <= ARSIZE;
        r_burst <= burst_t'(ARBURST);
        r_cnt   <= '0;
      end else if (w_r_hs && !w_last) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_state == StSend) r_addr <= w_next_addr;
      end
    end
  end

  always_comb begin
    ARREADY  = r_arready;
    RVALID   = (r_state == StSend) || (r_state == StErr);
    RID      = r_id;
    RRESP    = (r_state == StErr) ? RESP_SLVERR : RESP_OKAY;
    RLAST    = RVALID & w_last;
    RDATA    = '0;
    if (r_state == StSend) RDATA = r_fresh ? mem_rdata : r_rdata;
    mem_re   = (r_state == StFetch);
    mem_addr = mem_re ? (r_addr & ~BeatMask) : '0;
  end

endmodule
